cp0_exc_unit: RTL and testbench

//  Parametrised MIPS CP0 register file and precise-exception controller, instantiated beside WB.

---
 rtl/cp0_pkg.sv | 72 +++++++
 rtl/cp0_timer.sv | 79 +++++++
 rtl/cp0_exc_unit.sv | 160 ++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, ExcCode values, wb_exc bit positions
// and the exception-source priority helpers used by cp0_exc_unit.
package cp0_pkg;

    // {rd[4:0], sel[2:0]} addresses of the implemented registers
    localparam logic [7:0] REG_BADVADDR = 8'h40;
    localparam logic [7:0] REG_COUNT    = 8'h48;
    localparam logic [7:0] REG_COMPARE  = 8'h58;
    localparam logic [7:0] REG_STATUS   = 8'h60;
    localparam logic [7:0] REG_CAUSE    = 8'h68;
    localparam logic [7:0] REG_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int WB_ADEL_IF = 6;
    localparam int WB_RI      = 5;
    localparam int WB_OV      = 4;
    localparam int WB_SYS     = 3;
    localparam int WB_BP      = 2;
    localparam int WB_ADEL_LS = 1;
    localparam int WB_ADES    = 0;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_INT,
        SRC_ADEL_IF,
        SRC_RI,
        SRC_OV,
        SRC_SYS,
        SRC_BP,
        SRC_ADEL_LS,
        SRC_ADES
    } exc_src_e;

    // Highest-priority cause wins; everything below it is discarded.
    function automatic exc_src_e exc_select(input logic int_pend, input logic [6:0] exc);
        exc_src_e src;
        src = SRC_NONE;
        if (int_pend)              src = SRC_INT;
        else if (exc[WB_ADEL_IF])  src = SRC_ADEL_IF;
        else if (exc[WB_RI])       src = SRC_RI;
        else if (exc[WB_OV])       src = SRC_OV;
        else if (exc[WB_SYS])      src = SRC_SYS;
        else if (exc[WB_BP])       src = SRC_BP;
        else if (exc[WB_ADEL_LS])  src = SRC_ADEL_LS;
        else if (exc[WB_ADES])     src = SRC_ADES;
        return src;
    endfunction

    function automatic logic [4:0] exc_code_of(input exc_src_e src);
        logic [4:0] code;
        case (src)
            SRC_ADEL_IF, SRC_ADEL_LS: code = EXC_ADEL;
            SRC_ADES:                 code = EXC_ADES;
            SRC_RI:                   code = EXC_RI;
            SRC_OV:                   code = EXC_OV;
            SRC_SYS:                  code = EXC_SYS;
            SRC_BP:                   code = EXC_BP;
            default:                  code = EXC_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Prescaled Count/Compare timer with sticky TI. Present only when CP0_TIMER_EN is
// defined; otherwise Count/Compare read 0, writes are ignored and TI stays low.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

`ifdef CP0_TIMER_EN
    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_wen) begin
            count_d = wdata;
            div_d   = '0;
        end else if (div_q == DIV_W'(COUNT_DIV - 1)) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d = div_q + 1'b1;
        end

        // A Compare write clears TI even if Count reaches Compare on the same edge.
        if (compare_wen) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if ((count_d != count_q) && (count_d == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
`else
    logic unused_timer_inputs;
    assign unused_timer_inputs = ^{clk, reset, count_wen, compare_wen, wdata};

    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file and precise-exception controller beside WB. The Count/Compare
// timer is built only when CP0_TIMER_EN is defined.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int unsigned HW_INT_NUM = 5,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_pc,
    input  logic                  wb_in_delay,
    input  logic [6:0]            wb_exc,
    input  logic [31:0]           wb_badvaddr,
    input  logic                  wb_eret,
    input  logic                  mtc0_en,
    input  logic [7:0]            mtc0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic [7:0]            mfc0_addr,
    output logic [31:0]           mfc0_rdata,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  exc_valid,
    output logic [31:0]           exc_pc,
    output logic                  cancel,
    output logic                  status_exl
);

    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [HW_INT_NUM-1:0] hw_q, hw_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_pend;
    exc_src_e    exc_src;
    logic        exc_take, eret_take, mtc0_wen;

    always_comb begin
        ip        = '0;
        ip[1:0]   = ip_sw_q;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            ip[2+i] = hw_q[i];
        end
        ip[7]     = ti;
    end

    assign int_pend  = ie_q & ~exl_q & (|(ip & im_q));
    assign exc_src   = exc_select(int_pend, wb_exc);
    assign exc_take  = wb_valid & (exc_src != SRC_NONE);
    assign eret_take = wb_valid & wb_eret & ~exc_take;
    // A redirecting instruction cancels its own MTC0.
    assign mtc0_wen  = wb_valid & mtc0_en & ~exc_take & ~eret_take;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .count_wen   (mtc0_wen && (mtc0_addr == REG_COUNT)),
        .compare_wen (mtc0_wen && (mtc0_addr == REG_COMPARE)),
        .wdata       (mtc0_wdata),
        .count       (count),
        .compare     (compare),
        .ti          (ti)
    );

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        hw_d       = hw_int;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (mtc0_wen) begin
            case (mtc0_addr)
                REG_STATUS: begin
                    im_d  = mtc0_wdata[15:8];
                    exl_d = mtc0_wdata[1];
                    ie_d  = mtc0_wdata[0];
                end
                REG_CAUSE: ip_sw_d = mtc0_wdata[9:8];
                REG_EPC:   epc_d   = mtc0_wdata;
                default: ;
            endcase
        end

        if (exc_take) begin
            exc_code_d = exc_code_of(exc_src);
            exl_d      = 1'b1;
            // Nested exceptions keep the EPC/BD of the outermost one.
            if (!exl_q) begin
                epc_d = wb_in_delay ? (wb_pc - 32'd4) : wb_pc;
                bd_d  = wb_in_delay;
            end
            if (exc_src == SRC_ADEL_IF) begin
                badvaddr_d = wb_pc;
            end else if ((exc_src == SRC_ADEL_LS) || (exc_src == SRC_ADES)) begin
                badvaddr_d = wb_badvaddr;
            end
        end else if (eret_take) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            hw_q       <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            hw_q       <= hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            REG_BADVADDR: mfc0_rdata = badvaddr_q;
            REG_COUNT:    mfc0_rdata = count;
            REG_COMPARE:  mfc0_rdata = compare;
            REG_STATUS:   mfc0_rdata = {STATUS_RESET[31:16], im_q, 6'b0, exl_q, ie_q};
            REG_CAUSE:    mfc0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
            REG_EPC:      mfc0_rdata = epc_q;
            default: ;
        endcase
    end

    assign exc_valid  = ~reset & (exc_take | eret_take);
    assign cancel     = exc_valid;
    assign exc_pc     = exc_take ? EXC_ENTRY : epc_q;
    assign status_exl = exl_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit; timer steps follow CP0_TIMER_EN.
module tb_cp0_exc_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_in_delay;
    logic [6:0]  wb_exc;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic        mtc0_en;
    logic [7:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [7:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [4:0]  hw_int;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        cancel;
    logic        status_exl;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cp0_exc_unit #(
        .HW_INT_NUM (5),
        .COUNT_DIV  (2),
        .EXC_ENTRY  (32'hBFC0_0380)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .wb_in_delay (wb_in_delay),
        .wb_exc      (wb_exc),
        .wb_badvaddr (wb_badvaddr),
        .wb_eret     (wb_eret),
        .mtc0_en     (mtc0_en),
        .mtc0_addr   (mtc0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .mfc0_addr   (mfc0_addr),
        .mfc0_rdata  (mfc0_rdata),
        .hw_int      (hw_int),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .cancel      (cancel),
        .status_exl  (status_exl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        mfc0_addr = addr;
        #1;
        check(tag, mfc0_rdata, exp);
    endtask

    task automatic check_redirect(input string tag, input logic vld, input logic [31:0] pc);
        #1;
        check({tag, "_valid"}, {31'b0, exc_valid}, {31'b0, vld});
        check({tag, "_cancel"}, {31'b0, cancel}, {31'b0, vld});
        if (vld) check({tag, "_pc"}, exc_pc, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid    = 1'b0;
        wb_in_delay = 1'b0;
        wb_exc      = '0;
        wb_eret     = 1'b0;
        mtc0_en     = 1'b0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [6:0] exc, input logic dly);
        idle();
        wb_valid    = 1'b1;
        wb_pc       = pc;
        wb_exc      = exc;
        wb_in_delay = dly;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        idle();
        wb_valid   = 1'b1;
        wb_pc      = 32'h8000_0F00;
        mtc0_en    = 1'b1;
        mtc0_addr  = addr;
        mtc0_wdata = data;
    endtask

    task automatic eret();
        idle();
        wb_valid = 1'b1;
        wb_pc    = 32'h8000_0F04;
        wb_eret  = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        wb_pc       = '0;
        wb_badvaddr = '0;
        mtc0_addr   = '0;
        mtc0_wdata  = '0;
        mfc0_addr   = '0;
        hw_int      = '0;
        idle();
        tick();
        tick();

        // Reset state; an exception request during reset must not redirect
        instr(32'h8000_0000, 7'b0001000, 1'b0);
        check_redirect("rst_exc", 1'b0, 32'h0);
        check_reg("rst_status", REG_STATUS, 32'h0040_0000);
        check_reg("rst_cause", REG_CAUSE, 32'h0);
        check_reg("rst_epc", REG_EPC, 32'h0);
        check_reg("rst_badv", REG_BADVADDR, 32'h0);
        reset = 1'b0;

        // Hardware interrupt 0 enabled via IM[2]
        mtc0(REG_STATUS, 32'h0000_0401);
        hw_int = 5'b00001;
        check_redirect("mtc0_status", 1'b0, 32'h0);
        tick();
        instr(32'hBFC0_0100, 7'b0, 1'b0);
        check_redirect("hw_int", 1'b1, 32'hBFC0_0380);
        tick();
        idle();
        check_reg("int_cause", REG_CAUSE, 32'h0000_0400);
        check_reg("int_epc", REG_EPC, 32'hBFC0_0100);
        check_reg("int_status", REG_STATUS, 32'h0040_0403);
        check("int_exl", {31'b0, status_exl}, 32'd1);

        // Nested RI under EXL keeps EPC; interrupt is masked by EXL
        instr(32'h8000_1000, 7'b0100000, 1'b0);
        check_redirect("ri_nested", 1'b1, 32'hBFC0_0380);
        tick();
        idle();
        check_reg("ri_epc", REG_EPC, 32'hBFC0_0100);
        check_reg("ri_cause", REG_CAUSE, 32'h0000_0428);
        instr(32'h8000_1004, 7'b0, 1'b0);
        hw_int = 5'b00000;
        check_redirect("int_masked", 1'b0, 32'h0);
        tick();
        eret();
        check_redirect("eret1", 1'b1, 32'hBFC0_0100);
        tick();
        idle();
        check("eret1_exl", {31'b0, status_exl}, 32'd0);

        // OV beats SYS, delay-slot EPC adjustment
        instr(32'h8000_0010, 7'b0011000, 1'b1);
        check_redirect("ov_sys", 1'b1, 32'hBFC0_0380);
        tick();
        idle();
        check_reg("ov_epc", REG_EPC, 32'h8000_000C);
        check_reg("ov_cause", REG_CAUSE, 32'h8000_0030);
        eret();
        check_redirect("eret2", 1'b1, 32'h8000_000C);
        tick();

        // Data-side address error captures BadVAddr
        instr(32'h8000_0020, 7'b0000010, 1'b0);
        wb_badvaddr = 32'h0000_0003;
        tick();
        idle();
        check_reg("adel_badv", REG_BADVADDR, 32'h0000_0003);
        check_reg("adel_cause", REG_CAUSE, 32'h0000_0010);
        check_reg("adel_epc", REG_EPC, 32'h8000_0020);
        eret();
        check_redirect("eret3", 1'b1, 32'h8000_0020);
        tick();
        idle();
        check("eret3_exl", {31'b0, status_exl}, 32'd0);

        // Exception suppresses a same-cycle MTC0 to EPC
        mtc0(REG_EPC, 32'hDEAD_BEEF);
        wb_pc  = 32'h8000_0040;
        wb_exc = 7'b0000100;
        tick();
        idle();
        check_reg("bp_epc", REG_EPC, 32'h8000_0040);
        check_reg("bp_cause", REG_CAUSE, 32'h0000_0024);

        // adel_if outranks ri and ades; BadVAddr takes the PC
        instr(32'h8000_0050, 7'b1100001, 1'b0);
        tick();
        idle();
        check_reg("adelif_cause", REG_CAUSE, 32'h0000_0010);
        check_reg("adelif_badv", REG_BADVADDR, 32'h8000_0050);
        check_reg("adelif_epc", REG_EPC, 32'h8000_0040);
        eret();
        check_redirect("eret4", 1'b1, 32'h8000_0040);
        tick();

        // Software interrupt: Cause write touches only IP[1:0]
        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        tick();
        idle();
        check_reg("sw_cause", REG_CAUSE, 32'h0000_0310);
        mtc0(REG_STATUS, 32'h0000_0101);
        check_redirect("sw_masked", 1'b0, 32'h0);
        tick();
        instr(32'h8000_0060, 7'b0, 1'b0);
        check_redirect("sw_int", 1'b1, 32'hBFC0_0380);
        tick();
        idle();
        check_reg("sw_int_cause", REG_CAUSE, 32'h0000_0300);
        check_reg("sw_int_epc", REG_EPC, 32'h8000_0060);
        mtc0(REG_CAUSE, 32'h0);
        tick();
        eret();
        tick();
        idle();
        check_reg("unimpl", 8'h00, 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(REG_COUNT, 32'h0);
        tick();
        mtc0(REG_COMPARE, 32'd10);
        tick();
        idle();
        repeat (18) tick();
        check_reg("ti_before", REG_CAUSE, 32'h0);
        tick();
        check_reg("ti_set", REG_CAUSE, 32'h4000_8000);
        check_reg("ti_count", REG_COUNT, 32'd10);
        mtc0(REG_COMPARE, 32'd10);
        tick();
        idle();
        check_reg("ti_clear", REG_CAUSE, 32'h0);
        mtc0(REG_COUNT, 32'h0);
        tick();
        idle();
        repeat (19) tick();
        mtc0(REG_COMPARE, 32'd10);
        tick();
        idle();
        check_reg("ti_race_count", REG_COUNT, 32'd10);
        check_reg("ti_race", REG_CAUSE, 32'h0);
        tick();
        check_reg("ti_race_hold", REG_CAUSE, 32'h0);
`else
        mtc0(REG_COUNT, 32'h0000_1234);
        tick();
        mtc0(REG_COMPARE, 32'h0000_0055);
        tick();
        idle();
        check_reg("no_timer_count", REG_COUNT, 32'h0);
        check_reg("no_timer_compare", REG_COMPARE, 32'h0);
        repeat (4) tick();
        check_reg("no_timer_cause", REG_CAUSE, 32'h0);
`endif

        // Reset arriving on an exception-take cycle
        instr(32'h8000_0070, 7'b0001000, 1'b0);
        tick();
        instr(32'h8000_0074, 7'b0001000, 1'b0);
        reset = 1'b1;
        check_redirect("rst_take", 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        check_reg("rst2_status", REG_STATUS, 32'h0040_0000);
        check_reg("rst2_cause", REG_CAUSE, 32'h0);
        check("rst2_exl", {31'b0, status_exl}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
